// File: rtl/bht_predictor.sv
// Branch history table predictor: 2^INDEX_BITS saturating counters indexed by
// the PC. When HIST_BITS > 0 the index is XORed with a global history register
// (gshare). Each cycle it serves one prediction request and one resolved-branch
// update, and it counts updates and mispredicts.
//
// Handshake: a request is accepted on every posedge where req_valid is high, and
// pred_valid is high for exactly one cycle afterwards. There is no back-pressure.
// An update is applied on every posedge where upd_valid is high. rst overrides
// both inputs in the same cycle.
module bht_predictor #(
   parameter int PC_BITS    = 32,
   parameter int INDEX_BITS = 6,
   parameter int CTR_BITS   = 2,
   parameter int HIST_BITS  = 4,
   parameter int STAT_BITS  = 16,
   localparam int GHR_W     = (HIST_BITS > 0) ? HIST_BITS : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic [PC_BITS-1:0]    req_pc,
   output logic                  pred_valid,
   output logic                  pred_taken,
   output logic [INDEX_BITS-1:0] pred_index,
   input  logic                  upd_valid,
   input  logic [INDEX_BITS-1:0] upd_index,
   input  logic                  upd_taken,
   input  logic                  upd_pred,
   output logic [STAT_BITS-1:0]  upd_count,
   output logic [STAT_BITS-1:0]  miss_count,
   output logic [GHR_W-1:0]      ghr
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   // Reset value is "weakly taken": the MSB is set and all other bits are clear.
   localparam logic [CTR_BITS-1:0]  CTR_INIT = {1'b1, {(CTR_BITS-1){1'b0}}};
   localparam logic [CTR_BITS-1:0]  CTR_MAX  = {CTR_BITS{1'b1}};
   localparam logic [CTR_BITS-1:0]  CTR_MIN  = {CTR_BITS{1'b0}};
   localparam logic [CTR_BITS-1:0]  CTR_ONE  = {{(CTR_BITS-1){1'b0}}, 1'b1};
   localparam logic [STAT_BITS-1:0] STAT_MAX = {STAT_BITS{1'b1}};
   localparam logic [STAT_BITS-1:0] STAT_ONE = {{(STAT_BITS-1){1'b0}}, 1'b1};

   // Counter table and registered state.
   logic [CTR_BITS-1:0]   ctr_q [ENTRIES];
   logic [GHR_W-1:0]      ghr_q, ghr_d;
   logic                  pred_valid_q, pred_valid_d;
   logic                  pred_taken_q, pred_taken_d;
   logic [INDEX_BITS-1:0] pred_index_q, pred_index_d;
   logic [STAT_BITS-1:0]  upd_count_q, upd_count_d;
   logic [STAT_BITS-1:0]  miss_count_q, miss_count_d;

   // Combinational helpers.
   logic [INDEX_BITS-1:0] ghr_ext;
   logic [INDEX_BITS-1:0] req_idx;
   logic [CTR_BITS-1:0]   upd_cur;
   logic [CTR_BITS-1:0]   upd_new;
   logic [CTR_BITS-1:0]   rd_ctr;

   // Only the word-aligned index bits of the PC take part in the hash.
   generate
      if (PC_BITS > INDEX_BITS + 2) begin : g_pc_hi
         logic unused_pc;
         assign unused_pc = ^{req_pc[PC_BITS-1:INDEX_BITS+2], req_pc[1:0]};
      end else begin : g_pc_lo
         logic unused_pc;
         assign unused_pc = ^req_pc[1:0];
      end
   endgenerate

   // Zero-extend the history into the low index bits. With HIST_BITS=0 the
   // history register stays at zero, so the result is pure bimodal indexing.
   always_comb begin
      ghr_ext = '0;
      ghr_ext[GHR_W-1:0] = ghr_q;
   end

   assign req_idx = req_pc[INDEX_BITS+1:2] ^ ghr_ext;

   // Saturating increment or decrement of the counter being updated.
   always_comb begin
      upd_cur = ctr_q[upd_index];
      upd_new = upd_cur;
      if (upd_taken) begin
         if (upd_cur != CTR_MAX) upd_new = upd_cur + CTR_ONE;
      end else begin
         if (upd_cur != CTR_MIN) upd_new = upd_cur - CTR_ONE;
      end
   end

   // Write-through bypass: a request that reads the entry being updated in the
   // same cycle sees the new value.
   always_comb begin
      rd_ctr = ctr_q[req_idx];
      if (upd_valid && (upd_index == req_idx)) rd_ctr = upd_new;
   end

   // Prediction next state: direction and index hold when there is no request.
   always_comb begin
      pred_valid_d = req_valid;
      pred_taken_d = pred_taken_q;
      pred_index_d = pred_index_q;
      if (req_valid) begin
         pred_taken_d = rd_ctr[CTR_BITS-1];
         pred_index_d = req_idx;
      end
   end

   // History shifts in resolved outcomes only, so it is never speculative.
   generate
      if (HIST_BITS == 0) begin : g_no_hist
         always_comb begin
            ghr_d = '0;
         end
      end else if (HIST_BITS == 1) begin : g_hist1
         always_comb begin
            ghr_d = ghr_q;
            if (upd_valid) ghr_d = upd_taken;
         end
      end else begin : g_histn
         always_comb begin
            ghr_d = ghr_q;
            if (upd_valid) ghr_d = {ghr_q[HIST_BITS-2:0], upd_taken};
         end
      end
   endgenerate

   // Statistics counters saturate at all-ones and never wrap.
   always_comb begin
      upd_count_d  = upd_count_q;
      miss_count_d = miss_count_q;
      if (upd_valid) begin
         if (upd_count_q != STAT_MAX) upd_count_d = upd_count_q + STAT_ONE;
         if ((upd_pred != upd_taken) && (miss_count_q != STAT_MAX))
            miss_count_d = miss_count_q + STAT_ONE;
      end
   end

   // Counter table: reset to weakly taken, otherwise write the updated entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_INIT;
      end else if (upd_valid) begin
         ctr_q[upd_index] <= upd_new;
      end
   end

   // Prediction, history and statistics registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         ghr_q        <= '0;
         pred_valid_q <= 1'b0;
         pred_taken_q <= 1'b0;
         pred_index_q <= '0;
         upd_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         ghr_q        <= ghr_d;
         pred_valid_q <= pred_valid_d;
         pred_taken_q <= pred_taken_d;
         pred_index_q <= pred_index_d;
         upd_count_q  <= upd_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign pred_valid = pred_valid_q;
   assign pred_taken = pred_taken_q;
   assign pred_index = pred_index_q;
   assign upd_count  = upd_count_q;
   assign miss_count = miss_count_q;
   assign ghr        = ghr_q;

endmodule
